instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Parametrised multi-push / multi-pop circular instruction queue between fetch (IF1) and decode.
- Accepts up to PUSH_W entries per cycle from fetch and presents up to POP_W head entries per cycle to decode.
- Successor to the fixed 4-in/2-out buffer. Adds:
  - explicit push back-pressure (no overflow);
  - clamped pop (no underflow);
  - occupancy-based lane valids;
  - correct-width count arithmetic;
  - deterministic zeroed outputs on empty lanes.

Parameters:
- DATA_W, 64: width of one entry (instr, pc and predecode bits).
- DEPTH, 16: number of entries. Must be a power of two and at least PUSH_W + POP_W.
- PUSH_W, 4: maximum entries pushed per cycle.
- POP_W, 2: maximum entries popped per cycle.
- Derived, local:
  - AW = clog2(DEPTH).
  - CW = AW + 1.
  - PNW = clog2(PUSH_W+1).
  - QNW = clog2(POP_W+1).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- flush, in, 1: synchronous discard of all contents (redirect or exception).
- push_valid, in, 1: fetch offers push_num entries this cycle.
- push_num, in, PNW: number of entries offered, 0..PUSH_W. Lane 0 is oldest.
- push_data, in, PUSH_W*DATA_W: lane i occupies bits [i*DATA_W +: DATA_W].
- push_ready, out, 1: high when free >= PUSH_W.
- out_valid, out, POP_W: bit i high iff count > i (prefix mask).
- out_data, out, POP_W*DATA_W: entry at head+i, or zero when out_valid[i] is low.
- pop_num, in, QNW: entries consumed this cycle, 0..POP_W.
- count, out, CW: current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x DATA_W array, not reset. head and tail are AW-bit pointers that wrap naturally modulo DEPTH. count is a CW-bit register.
- Reset (rst=1 at posedge): head=0, tail=0, count=0. The following cycle shows out_valid=0, out_data=0, push_ready=1 (given DEPTH >= PUSH_W).
- Flush: identical effect to reset. flush overrides any push or pop in the same cycle; nothing is written.
- Push acceptance:
  - push_fire = push_valid & push_ready & (push_num != 0).
  - Acceptance is decided on free = DEPTH - count at the start of the cycle. Same-cycle pops are not credited.
  - push_num > PUSH_W is illegal and treated as 0. A simulation assertion flags it.
  - On push_fire, lanes 0..push_num-1 are written to tail..tail+push_num-1 (mod DEPTH), and tail advances by push_num.
  - When push_valid=1 and push_ready=0, nothing is written. Fetch must hold and retry.
- Pop:
  - eff_pop = min(pop_num, count, POP_W). Popping more than count is clamped and asserted in simulation.
  - head advances by eff_pop.
- Read path: combinational from head, zero latency. An entry pushed at edge N is visible on out_data after edge N; there is no bypass from push_data to out_data.
- Count update:
  - count_next = count + (push_fire ? push_num : 0) - eff_pop.
  - All operands are zero-extended to CW bits.
  - count never exceeds DEPTH and never goes below 0.
- Simultaneous push and pop: both apply in the same cycle, including when count=DEPTH-PUSH_W or count=0. A pop with count=0 has no effect.
- Wrap-around: the writes of a single push may straddle index DEPTH-1 to 0, and the head window may straddle the same boundary. Both must be correct.
- Full: count=DEPTH, push_ready=0, and all out_valid lanes are set.
- Empty: count=0, out_valid=0, out_data=0.

Decomposition:
- Shared package or define header (existing define.vh):
  - default DATA_W (IB_DATA_BUS_WD);
  - DEPTH (IB_WIDTH) and AW (IB_WIDTH_LOG2);
  - PUSH_W and POP_W constants for the core-wide fetch and decode widths.
- No sub-module required. Optionally, instr_queue_rd_mux holds the head-window read mux with zero-masking, reused for POP_W lanes.

Test Plan (DEPTH=8, PUSH_W=4, POP_W=2, DATA_W=16):
- Reset, then idle → count=0, out_valid=2'b00, out_data=0, push_ready=1.
- Push 4 entries {A0,A1,A2,A3} with pop_num=0 → next cycle count=4, out_valid=2'b11, out_data lanes = A0, A1. Then pop_num=2 → count=2, lanes = A2, A3.
- Three consecutive push_num=4 with no pop → 1st and 2nd accepted (count=8). 3rd: push_ready=0, count stays 8, no data corrupted.
- Wrap case:
  - Setup: push 4, pop 2 x2, push 4, push 3 with pops interleaved, so tail crosses 7→0.
  - Required: FIFO order is preserved across the wrap, and out_data lane 1 is correctly taken from index 0 when head=7.
- Underflow clamp: count=1 with entry B0, pop_num=2 → out_valid=2'b01 before the edge; after the edge count=0, head advanced by 1, and out_data lane 1 = 0 throughout.
- Flush priority: count=5, flush=1 together with push_num=3 and pop_num=2 → next cycle count=0 and out_valid=0. A following push of {C0} gives out_data lane 0 = C0.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// rtl/instr_queue_pkg.sv - core-wide instruction queue sizing constants
package instr_queue_pkg;

    // Entry width: instruction, pc and predecode bits
    localparam int IQ_DATA_W = 64;
    // Queue depth (power of two) and its pointer width
    localparam int IQ_DEPTH  = 16;
    localparam int IQ_AW     = $clog2(IQ_DEPTH);
    // Fetch and decode widths of the core
    localparam int IQ_PUSH_W = 4;
    localparam int IQ_POP_W  = 2;

endpackage

// File: rtl/instr_queue_rd_mux.sv
// rtl/instr_queue_rd_mux.sv - head-window read mux with zero-masked empty lanes
module instr_queue_rd_mux
    import instr_queue_pkg::*;
#(
    parameter int DATA_W = IQ_DATA_W,
    parameter int DEPTH  = IQ_DEPTH,
    parameter int POP_W  = IQ_POP_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic [DATA_W-1:0]       mem [DEPTH],
    input  logic [AW-1:0]           head,
    input  logic [CW-1:0]           count,
    output logic [POP_W-1:0]        out_valid,
    output logic [POP_W*DATA_W-1:0] out_data
);

    logic [AW-1:0] idx;

    // Lane i shows the entry at head+i (wrapping modulo DEPTH) when occupancy covers it, else zero
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        idx       = '0;
        for (int i = 0; i < POP_W; i++) begin
            idx          = head + AW'(i);
            out_valid[i] = count > CW'(i);
            if (out_valid[i]) begin
                out_data[i*DATA_W +: DATA_W] = mem[idx];
            end
        end
    end

endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - multi-push / multi-pop circular queue between fetch and decode
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DATA_W = IQ_DATA_W,
    parameter int DEPTH  = IQ_DEPTH,
    parameter int PUSH_W = IQ_PUSH_W,
    parameter int POP_W  = IQ_POP_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1,
    localparam int PNW   = $clog2(PUSH_W + 1),
    localparam int QNW   = $clog2(POP_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_valid,
    input  logic [PNW-1:0]           push_num,
    input  logic [PUSH_W*DATA_W-1:0] push_data,
    output logic                     push_ready,
    output logic [POP_W-1:0]         out_valid,
    output logic [POP_W*DATA_W-1:0]  out_data,
    input  logic [QNW-1:0]           pop_num,
    output logic [CW-1:0]            count
);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] PUSH_W_C = CW'(PUSH_W);
    localparam logic [CW-1:0] POP_W_C  = CW'(POP_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     free;
    logic              push_legal;
    logic              push_fire;
    logic [CW-1:0]     push_cnt;
    logic [CW-1:0]     pop_req;
    logic [CW-1:0]     eff_pop;

    // Acceptance looks only at start-of-cycle space; a same-cycle pop is never credited
    assign free       = DEPTH_C - count_q;
    assign push_ready = free >= PUSH_W_C;
    assign push_legal = push_num <= PNW'(PUSH_W);
    assign push_fire  = push_valid & push_ready & push_legal & (push_num != '0);
    assign push_cnt   = push_fire ? CW'(push_num) : '0;
    assign count      = count_q;

    // Clamp the requested pop to the lane count and to what is actually held
    always_comb begin
        pop_req = CW'(pop_num);
        if (pop_req > POP_W_C) begin
            pop_req = POP_W_C;
        end
        eff_pop = (pop_req > count_q) ? count_q : pop_req;
    end

    // Pointer and occupancy update; flush behaves exactly like reset and wins over push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + eff_pop[AW-1:0];
            tail    <= tail + push_cnt[AW-1:0];
            count_q <= count_q + push_cnt - eff_pop;
        end
    end

    // Storage write of lanes 0..push_num-1 at tail onward, wrapping past DEPTH-1; array is not reset
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_fire) begin
            for (int i = 0; i < PUSH_W; i++) begin
                if (PNW'(i) < push_num) begin
                    mem[tail + AW'(i)] <= push_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    instr_queue_rd_mux #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .POP_W  (POP_W)
    ) u_rd_mux (
        .mem       (mem),
        .head      (head),
        .count     (count_q),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // Simulation-only flags for illegal push sizes and popping past occupancy
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push_valid && !push_legal))
                else $error("instr_queue: push_num %0d exceeds PUSH_W %0d", push_num, PUSH_W);
            assert (CW'(pop_num) <= count_q)
                else $warning("instr_queue: pop_num %0d exceeds count %0d, clamped", pop_num, count_q);
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - directed scoreboard bench for instr_queue
module tb_instr_queue;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int PUSH_W = 4;
    localparam int POP_W  = 2;
    localparam int PNW    = 3;
    localparam int QNW    = 2;
    localparam int CW     = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     push_valid;
    logic [PNW-1:0]           push_num;
    logic [PUSH_W*DATA_W-1:0] push_data;
    logic                     push_ready;
    logic [POP_W-1:0]         out_valid;
    logic [POP_W*DATA_W-1:0]  out_data;
    logic [QNW-1:0]           pop_num;
    logic [CW-1:0]            count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_q[$];
    int          model_head = 0;
    bit          model_ok = 1'b0;

    instr_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PUSH_W (PUSH_W),
        .POP_W  (POP_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_num   (push_num),
        .push_data  (push_data),
        .push_ready (push_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .pop_num    (pop_num),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int          sz;
        logic [1:0]  ev;
        logic [15:0] e0;
        logic [15:0] e1;
        sz = model_q.size();
        ev = {sz > 1, sz > 0};
        e0 = (sz > 0) ? model_q[0] : 16'h0;
        e1 = (sz > 1) ? model_q[1] : 16'h0;
        chk({tag, ".count"},      32'(count),       32'(sz));
        chk({tag, ".out_valid"},  32'(out_valid),   32'(ev));
        chk({tag, ".lane0"},      32'(out_data[15:0]),  32'(e0));
        chk({tag, ".lane1"},      32'(out_data[31:16]), 32'(e1));
        chk({tag, ".push_ready"}, 32'(push_ready),  32'((DEPTH - sz) >= PUSH_W));
        chk({tag, ".head"},       32'(u_dut.head),  32'(model_head));
    endtask

    // One clock: drive inputs, check pre-edge outputs against the model, then advance the model
    task automatic cycle(input string tag, input logic pv, input int pn,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3,
                         input int pop, input logic fl);
        bit          accept;
        int          eff;
        logic [15:0] lanes [4];
        lanes      = '{d0, d1, d2, d3};
        push_valid = pv;
        push_num   = PNW'(pn);
        push_data  = {d3, d2, d1, d0};
        pop_num    = QNW'(pop);
        flush      = fl;
        @(negedge clk);
        if (model_ok) check_all(tag);
        accept = pv && (pn > 0) && (pn <= PUSH_W) && ((DEPTH - model_q.size()) >= PUSH_W);
        @(posedge clk);
        if (rst || fl) begin
            model_q.delete();
            model_head = 0;
        end else begin
            eff = pop;
            if (eff > POP_W) eff = POP_W;
            if (eff > model_q.size()) eff = model_q.size();
            for (int k = 0; k < eff; k++) void'(model_q.pop_front());
            model_head = (model_head + eff) % DEPTH;
            if (accept) begin
                for (int k = 0; k < pn; k++) model_q.push_back(lanes[k]);
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_num = '0; push_data = '0; pop_num = '0;
        cycle("rst0", 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rst1", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_ok = 1'b1;

        // reset state, then push four and pop in pairs
        cycle("idle",  0, 0, 0, 0, 0, 0, 0, 0);
        cycle("pushA", 1, 4, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 0, 0);
        cycle("popA0", 0, 0, 0, 0, 0, 0, 2, 0);
        cycle("popA1", 0, 0, 0, 0, 0, 0, 2, 0);

        // fill to full, third push back-pressured, then drain
        cycle("fill0", 1, 4, 16'hB100, 16'hB101, 16'hB102, 16'hB103, 0, 0);
        cycle("fill1", 1, 4, 16'hB104, 16'hB105, 16'hB106, 16'hB107, 0, 0);
        cycle("fill2", 1, 4, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 0, 0);
        cycle("full",  0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle("drain", 0, 0, 0, 0, 0, 0, 2, 0);

        // wrap-around with head at index 7
        rst = 1'b1;
        cycle("rstw", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cycle("wpush0", 1, 4, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 0, 0);
        cycle("wpop0",  0, 0, 0, 0, 0, 0, 2, 0);
        cycle("wpop1",  0, 0, 0, 0, 0, 0, 2, 0);
        cycle("wpush1", 1, 4, 16'hC104, 16'hC105, 16'hC106, 16'hC107, 0, 0);
        cycle("wpush2", 1, 3, 16'hC200, 16'hC201, 16'hC202, 16'hFFFF, 2, 0);
        cycle("wpop2",  0, 0, 0, 0, 0, 0, 1, 0);
        cycle("whead7", 0, 0, 0, 0, 0, 0, 2, 0);
        cycle("wpop3",  0, 0, 0, 0, 0, 0, 2, 0);
        cycle("wempty", 0, 0, 0, 0, 0, 0, 0, 0);

        // underflow clamp with a single entry
        cycle("upush",  1, 1, 16'hB000, 16'h1111, 16'h2222, 16'h3333, 0, 0);
        cycle("upop",   0, 0, 0, 0, 0, 0, 2, 0);
        cycle("uafter", 0, 0, 0, 0, 0, 0, 0, 0);

        // flush overrides simultaneous push and pop
        cycle("fpush0", 1, 4, 16'hE000, 16'hE001, 16'hE002, 16'hE003, 0, 0);
        cycle("fpush1", 1, 1, 16'hE004, 16'h0, 16'h0, 16'h0, 0, 0);
        cycle("flush",  1, 3, 16'hF000, 16'hF001, 16'hF002, 16'h0, 2, 1);
        cycle("cpush",  1, 1, 16'hC0C0, 16'h0, 16'h0, 16'h0, 0, 0);
        cycle("cidle",  0, 0, 0, 0, 0, 0, 0, 0);
        cycle("cfinal", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
